// File: rtl/path_delay_meter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// path_delay_meter: launch/capture delay meter around one inverter path.
// Optional min/max outputs when PATH_DELAY_MINMAX_EN is defined.
// Revision: 1.0
// ----------------------------------------------------------------------------
module path_delay_meter #(
    parameter int CNT_W         = 12,
    parameter int TRIALS_LOG2   = 3,
    parameter int SYNC_STAGES   = 2,
    parameter int TIMEOUT       = 1000,
    parameter int SETTLE_CYCLES = 4,
    parameter int INVERTING     = 0
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         start,
    output logic                         pathInput,
    input  logic                         pathResult,
    output logic                         busy,
    output logic [CNT_W+TRIALS_LOG2-1:0] delaySum,
    output logic [CNT_W-1:0]             delayAvg,
    output logic                         timeoutFlag,
    output logic                         resultValid,
    input  logic                         resultReady
`ifdef PATH_DELAY_MINMAX_EN
    ,
    output logic [CNT_W-1:0]             delayMin,
    output logic [CNT_W-1:0]             delayMax
`endif
);

    localparam int                     SUM_W       = CNT_W + TRIALS_LOG2;
    localparam logic [CNT_W-1:0]       TIMEOUT_C   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]       SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic                   INV_C       = (INVERTING != 0);
    localparam logic [TRIALS_LOG2-1:0] TRIAL_LAST  = '1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_SETTLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic                     path_in_q, path_in_d;
    logic [SYNC_STAGES-1:0]   sync_q, sync_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [TRIALS_LOG2-1:0]   trial_q, trial_d;
    logic [SUM_W-1:0]         acc_q, acc_d;
    logic [SUM_W-1:0]         sum_q, sum_d;
    logic [CNT_W-1:0]         avg_q, avg_d;
    logic                     timeout_q, timeout_d;
    logic                     match;
`ifdef PATH_DELAY_MINMAX_EN
    logic [CNT_W-1:0]         min_q, min_d, max_q, max_d;
    logic [CNT_W-1:0]         dmin_q, dmin_d, dmax_q, dmax_d;
`endif

    // The expected level follows the already-toggled drive, corrected for path parity.
    assign match = (sync_q[SYNC_STAGES-1] == (path_in_q ^ INV_C));

    always_comb begin
        state_d   = state_q;
        path_in_d = path_in_q;
        sync_d    = {sync_q[SYNC_STAGES-2:0], pathResult};
        cnt_d     = cnt_q;
        trial_d   = trial_q;
        acc_d     = acc_q;
        sum_d     = sum_q;
        avg_d     = avg_q;
        timeout_d = timeout_q;
`ifdef PATH_DELAY_MINMAX_EN
        min_d     = min_q;
        max_d     = max_q;
        dmin_d    = dmin_q;
        dmax_d    = dmax_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d     = '0;
                    trial_d   = '0;
                    timeout_d = 1'b0;
`ifdef PATH_DELAY_MINMAX_EN
                    min_d     = '1;
                    max_d     = '0;
`endif
                    state_d   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                path_in_d = ~path_in_q;
                cnt_d     = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (match) begin
                    acc_d   = acc_q + SUM_W'(cnt_q);
`ifdef PATH_DELAY_MINMAX_EN
                    if (cnt_q < min_q) min_d = cnt_q;
                    if (cnt_q > max_q) max_d = cnt_q;
`endif
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end else if (cnt_q == TIMEOUT_C) begin
                    timeout_d = 1'b1;
                    sum_d     = '1;
                    avg_d     = '1;
`ifdef PATH_DELAY_MINMAX_EN
                    dmin_d    = '1;
                    dmax_d    = '1;
`endif
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d = '0;
                    if (trial_q == TRIAL_LAST) begin
                        sum_d   = acc_q;
                        avg_d   = acc_q[SUM_W-1:TRIALS_LOG2];
`ifdef PATH_DELAY_MINMAX_EN
                        dmin_d  = min_q;
                        dmax_d  = max_q;
`endif
                        state_d = S_DONE;
                    end else begin
                        trial_d = trial_q + TRIALS_LOG2'(1);
                        state_d = S_LAUNCH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (resultReady) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= S_IDLE;
            path_in_q <= 1'b0;
            sync_q    <= '0;
            cnt_q     <= '0;
            trial_q   <= '0;
            acc_q     <= '0;
            sum_q     <= '0;
            avg_q     <= '0;
            timeout_q <= 1'b0;
`ifdef PATH_DELAY_MINMAX_EN
            min_q     <= '1;
            max_q     <= '0;
            dmin_q    <= '0;
            dmax_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            path_in_q <= path_in_d;
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            trial_q   <= trial_d;
            acc_q     <= acc_d;
            sum_q     <= sum_d;
            avg_q     <= avg_d;
            timeout_q <= timeout_d;
`ifdef PATH_DELAY_MINMAX_EN
            min_q     <= min_d;
            max_q     <= max_d;
            dmin_q    <= dmin_d;
            dmax_q    <= dmax_d;
`endif
        end
    end

    assign pathInput   = path_in_q;
    assign busy        = (state_q != S_IDLE);
    assign resultValid = (state_q == S_DONE);
    assign delaySum    = sum_q;
    assign delayAvg    = avg_q;
    assign timeoutFlag = timeout_q;
`ifdef PATH_DELAY_MINMAX_EN
    assign delayMin    = dmin_q;
    assign delayMax    = dmax_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_path_delay_meter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_path_delay_meter: self-checking bench with a cycle-level path model.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_path_delay_meter;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        start = 1'b0;
    logic        resultReady = 1'b0;
    logic        pathInput;
    logic        pathResult;
    logic        busy;
    logic [14:0] delaySum;
    logic [11:0] delayAvg;
    logic        timeoutFlag;
    logic        resultValid;
`ifdef PATH_DELAY_MINMAX_EN
    logic [11:0] delayMin;
    logic [11:0] delayMax;
`endif

    path_delay_meter dut (
        .clk         (clk),
        .resetN      (resetN),
        .start       (start),
        .pathInput   (pathInput),
        .pathResult  (pathResult),
        .busy        (busy),
        .delaySum    (delaySum),
        .delayAvg    (delayAvg),
        .timeoutFlag (timeoutFlag),
        .resultValid (resultValid),
        .resultReady (resultReady)
`ifdef PATH_DELAY_MINMAX_EN
        ,
        .delayMin    (delayMin),
        .delayMax    (delayMax)
`endif
    );

    always #5 clk = ~clk;

    // Path model: rising edges arrive dr cycles late, falling edges df cycles late.
    int   dr = 0;
    int   df = 0;
    logic stuck = 1'b0;
    logic path_q = 1'b0;
    logic last_in = 1'b0;
    logic tgt = 1'b0;
    int   rem = 0;
    int   toggles = 0;

    assign pathResult = stuck ? 1'b0 : ((dr == 0 && df == 0) ? pathInput : path_q);

    always @(posedge clk) begin
        if (pathInput !== last_in) begin
            last_in <= pathInput;
            toggles <= toggles + 1;
            tgt     <= pathInput;
            if ((pathInput ? dr : df) <= 1) begin
                rem    <= 0;
                path_q <= pathInput;
            end else begin
                rem <= (pathInput ? dr : df) - 1;
            end
        end else if (rem > 0) begin
            rem <= rem - 1;
            if (rem == 1) path_q <= tgt;
        end
    end

    int   n_checks = 0;
    int   n_fail = 0;
    logic model_level = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: walk the trials, each arriving SYNC cycles after the path edge.
    task automatic model(input int d_r, input int d_f, input logic stk, input logic lvl_in,
                         output logic [14:0] e_sum, output logic [11:0] e_avg,
                         output logic e_to, output int e_tog,
                         output logic [11:0] e_min, output logic [11:0] e_max,
                         output logic lvl_out);
        logic lvl;
        int   s;
        int   c;
        lvl = lvl_in; s = 0; e_to = 1'b0; e_tog = 0; e_min = 12'hFFF; e_max = 12'h0;
        for (int i = 0; i < 8; i++) begin
            lvl = ~lvl;
            e_tog++;
            if (stk && lvl) begin
                e_to = 1'b1;
                break;
            end
            c = stk ? SYNC : ((lvl ? d_r : d_f) + SYNC);
            s += c;
            if (c < int'(e_min)) e_min = 12'(c);
            if (c > int'(e_max)) e_max = 12'(c);
        end
        if (e_to) begin
            e_sum = 15'h7FFF; e_avg = 12'hFFF; e_min = 12'hFFF; e_max = 12'hFFF;
        end else begin
            e_sum = 15'(s); e_avg = 12'(s / 8);
        end
        lvl_out = lvl;
    endtask

    task automatic run_meas(input int d_r, input int d_f, input logic stk, input bit extra,
                            input int hold, input logic rdy_early,
                            input logic [14:0] e_sum, input logic [11:0] e_avg,
                            input logic e_to, input int e_tog,
                            input logic [11:0] e_min, input logic [11:0] e_max,
                            input string tag);
        int t0;
        int cyc;
        bit sent;
        dr = d_r; df = d_f; stuck = stk;
        resultReady = rdy_early;
        t0 = toggles;
        sent = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        for (cyc = 0; cyc < 3000 && !resultValid; cyc++) begin
            if (extra && !sent && (toggles - t0) == 2) begin
                start = 1'b1;
                sent = 1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check({tag, "_valid"}, 32'(resultValid), 32'd1);
        check({tag, "_sum"}, 32'(delaySum), 32'(e_sum));
        check({tag, "_avg"}, 32'(delayAvg), 32'(e_avg));
        check({tag, "_timeout"}, 32'(timeoutFlag), 32'(e_to));
        check({tag, "_launches"}, 32'(toggles - t0), 32'(e_tog));
`ifdef PATH_DELAY_MINMAX_EN
        check({tag, "_min"}, 32'(delayMin), 32'(e_min));
        check({tag, "_max"}, 32'(delayMax), 32'(e_max));
`else
        if (e_min > e_max && !e_to) $display("note: empty min/max range in %s", tag);
`endif
        if (!rdy_early) begin
            for (int h = 0; h < hold; h++) begin
                tick();
                check({tag, "_hold_valid"}, 32'(resultValid), 32'd1);
                check({tag, "_hold_sum"}, 32'(delaySum), 32'(e_sum));
                check({tag, "_hold_avg"}, 32'(delayAvg), 32'(e_avg));
            end
        end
        resultReady = 1'b1;
        tick();
        resultReady = 1'b0;
        check({tag, "_drop_valid"}, 32'(resultValid), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        repeat (20) tick();
    endtask

    typedef struct {
        int          dr;
        int          df;
        logic [14:0] sum;
        logic [11:0] avg;
        logic [11:0] mn;
        logic [11:0] mx;
    } vec_t;

    vec_t tbl[4];

    initial begin
        logic [14:0] m_sum;
        logic [11:0] m_avg, m_min, m_max;
        logic        m_to, m_lvl;
        int          m_tog, a, b, t0;

        tbl[0] = '{dr: 0,  df: 0, sum: 15'd16, avg: 12'd2, mn: 12'd2, mx: 12'd2};
        tbl[1] = '{dr: 5,  df: 3, sum: 15'd48, avg: 12'd6, mn: 12'd5, mx: 12'd7};
        tbl[2] = '{dr: 1,  df: 2, sum: 15'd28, avg: 12'd3, mn: 12'd3, mx: 12'd4};
        tbl[3] = '{dr: 12, df: 1, sum: 15'd68, avg: 12'd8, mn: 12'd3, mx: 12'd14};

        repeat (2) tick();
        check("rst_pathInput", 32'(pathInput), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(resultValid), 32'd0);
        check("rst_sum", 32'(delaySum), 32'd0);
        check("rst_avg", 32'(delayAvg), 32'd0);
        check("rst_timeout", 32'(timeoutFlag), 32'd0);
        resetN = 1'b1;
        repeat (3) tick();

        // Ready arrives early for the first row, and after a 20-cycle stall for the second.
        for (int i = 0; i < 4; i++) begin
            run_meas(tbl[i].dr, tbl[i].df, 1'b0, 1'b0, (i == 1) ? 20 : 2, (i == 0),
                     tbl[i].sum, tbl[i].avg, 1'b0, 8, tbl[i].mn, tbl[i].mx,
                     $sformatf("vec%0d", i));
        end

        for (int r = 0; r < 6; r++) begin
            a = int'($urandom_range(1, 12));
            b = int'($urandom_range(1, 12));
            model(a, b, 1'b0, model_level, m_sum, m_avg, m_to, m_tog, m_min, m_max, m_lvl);
            run_meas(a, b, 1'b0, 1'b0, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     m_sum, m_avg, m_to, m_tog, m_min, m_max, $sformatf("rnd%0d", r));
            model_level = m_lvl;
        end

        model(5, 3, 1'b0, model_level, m_sum, m_avg, m_to, m_tog, m_min, m_max, m_lvl);
        run_meas(5, 3, 1'b0, 1'b1, 1, 1'b0, m_sum, m_avg, m_to, m_tog, m_min, m_max, "start_in_wait");
        model_level = m_lvl;

        // Reset while trial 4 is waiting for its edge.
        dr = 5; df = 3; stuck = 1'b0;
        t0 = toggles;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 500 && (toggles - t0) < 4; c++) tick();
        check("midrst_reached_trial4", 32'(toggles - t0), 32'd4);
        tick();
        #3 resetN = 1'b0;
        #1;
        check("midrst_pathInput", 32'(pathInput), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(resultValid), 32'd0);
        check("midrst_sum", 32'(delaySum), 32'd0);
        check("midrst_avg", 32'(delayAvg), 32'd0);
        check("midrst_timeout", 32'(timeoutFlag), 32'd0);
        repeat (3) tick();
        resetN = 1'b1;
        model_level = 1'b0;
        repeat (20) tick();

        model(5, 3, 1'b0, model_level, m_sum, m_avg, m_to, m_tog, m_min, m_max, m_lvl);
        run_meas(5, 3, 1'b0, 1'b0, 1, 1'b0, m_sum, m_avg, m_to, m_tog, m_min, m_max, "after_rst");
        model_level = m_lvl;

        // Path output stuck low: the first rising launch never returns.
        model(0, 0, 1'b1, model_level, m_sum, m_avg, m_to, m_tog, m_min, m_max, m_lvl);
        run_meas(0, 0, 1'b1, 1'b0, 3, 1'b0, m_sum, m_avg, m_to, m_tog, m_min, m_max, "stuck0");
        model_level = m_lvl;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
